// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: CPU word width,
// instruction memory depth and the loader FSM state encoding.
package inst_loader_pkg;

   localparam int CPU_WIDTH           = 32;
   localparam int INST_MEM_ADDR_DEPTH = 1024;

   typedef enum logic [2:0] {
      IL_IDLE = 3'd0,
      IL_HDR  = 3'd1,
      IL_DATA = 3'd2,
      IL_CSUM = 3'd3,
      IL_DONE = 3'd4,
      IL_ERR  = 3'd5
   } il_state_e;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte-to-word assembler: first byte of a word lands in [7:0].
// word_done pulses combinationally with the 4th byte so the caller registers the word.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  idx;
   logic [31:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= 2'd0;
      end else if (clr) begin
         idx <= 2'd0;
      end else if (en) begin
         idx <= idx + 2'd1;
      end
   end

   // assembly register carries no reset; every lane is rewritten before it is used
   always_ff @(posedge clk) begin
      if (en) begin
         shreg[8*idx +: 8] <= din;
      end
   end

   assign word      = {din, shreg[23:0]};
   assign word_done = en && (idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: framed byte stream (LE count header, LE payload, XOR checksum)
// written word-by-word into instruction memory; holds the core until verified.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int                   DEPTH     = INST_MEM_ADDR_DEPTH,
   parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int                   CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_i,
   output logic                 byte_ready_o,
   output logic                 wr_en_o,
   output logic [CPU_WIDTH-1:0] wr_addr_o,
   output logic [CPU_WIDTH-1:0] wr_data_o,
   output logic                 cpu_hold_o,
   output logic                 load_done_o,
   output logic                 load_err_o,
   output logic [CNT_W-1:0]     word_cnt_o
);

   localparam logic [CPU_WIDTH-1:0] DEPTH_W = CPU_WIDTH'(DEPTH);

   il_state_e            state, state_nxt;
   logic                 xfer, start_load, pack_en, word_done, hdr_ovf, last_word;
   logic [31:0]          pack_word;
   logic [CNT_W-1:0]     n_words, word_cnt;
   logic [7:0]           csum;

   assign byte_ready_o = (state == IL_HDR) || (state == IL_DATA) || (state == IL_CSUM);
   assign load_done_o  = (state == IL_DONE);
   assign load_err_o   = (state == IL_ERR);
   assign cpu_hold_o   = (state != IL_DONE);
   assign word_cnt_o   = word_cnt;

   assign xfer       = byte_valid_i && byte_ready_o;
   assign start_load = start_i && ((state == IL_IDLE) || (state == IL_DONE) || (state == IL_ERR));
   assign pack_en    = xfer && ((state == IL_HDR) || (state == IL_DATA));
   assign hdr_ovf    = pack_word > DEPTH_W;
   assign last_word  = (word_cnt + CNT_W'(1)) == n_words;

   // header bytes and payload bytes share one packer
   byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_load),
      .en        (pack_en),
      .din       (byte_i),
      .word      (pack_word),
      .word_done (word_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IL_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IL_IDLE: if (start_i) state_nxt = IL_HDR;
         IL_HDR: begin
            if (word_done) begin
               if (hdr_ovf)                 state_nxt = IL_ERR;
               else if (pack_word == 32'd0) state_nxt = IL_CSUM;
               else                         state_nxt = IL_DATA;
            end
         end
         IL_DATA: if (word_done && last_word) state_nxt = IL_CSUM;
         IL_CSUM: if (xfer) state_nxt = (byte_i == csum) ? IL_DONE : IL_ERR;
         IL_DONE: if (start_i) state_nxt = IL_HDR;
         IL_ERR:  if (start_i) state_nxt = IL_HDR;
         default: state_nxt = IL_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_o   <= 1'b0;
         wr_addr_o <= BASE_ADDR;
         wr_data_o <= '0;
         word_cnt  <= '0;
         n_words   <= '0;
         csum      <= 8'h00;
      end else begin
         wr_en_o <= 1'b0;
         if (start_load) begin
            word_cnt <= '0;
            csum     <= 8'h00;
         end
         if ((state == IL_HDR) && word_done && !hdr_ovf) begin
            n_words <= pack_word[CNT_W-1:0];
         end
         if ((state == IL_DATA) && pack_en) begin
            csum <= csum ^ byte_i;
         end
         // address wraps naturally at CPU_WIDTH bits
         if ((state == IL_DATA) && word_done) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= BASE_ADDR + (CPU_WIDTH'(word_cnt) << 2);
            wr_data_o <= pack_word;
            word_cnt  <= word_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: frames built from word lists, expected
// writes and final status derived from the frame rules, random valid gaps.
module tb_inst_loader;
   import inst_loader_pkg::*;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic             byte_valid_i = 1'b0;
   logic [7:0]       byte_i = 8'h00;
   logic             byte_ready_o, wr_en_o, cpu_hold_o, load_done_o, load_err_o;
   logic [31:0]      wr_addr_o, wr_data_o;
   logic [CNT_W-1:0] word_cnt_o;

   int n_vec = 0;
   int n_bad = 0;
   int n_writes = 0;

   logic [7:0]  frame_q[$];
   logic [31:0] pay_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .cpu_hold_o   (cpu_hold_o),
      .load_done_o  (load_done_o),
      .load_err_o   (load_err_o),
      .word_cnt_o   (word_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write-port scoreboard
   always @(negedge clk) begin
      if (!rst && wr_en_o) begin
         n_writes++;
         if (exp_addr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            check("wr_addr", wr_addr_o, exp_addr_q.pop_front());
            check("wr_data", wr_data_o, exp_data_q.pop_front());
         end
      end
   end

   // Builds frame_q from header count n and payload pay_q; fills expected writes.
   task automatic build_frame(input logic [31:0] n, input bit bad_csum);
      logic [7:0]  cs;
      logic [31:0] w;
      frame_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      cs = 8'h00;
      for (int i = 0; i < 4; i++) frame_q.push_back(n[8*i +: 8]);
      if (n <= 32'(DEPTH)) begin
         for (int k = 0; k < pay_q.size(); k++) begin
            w = pay_q[k];
            for (int i = 0; i < 4; i++) begin
               frame_q.push_back(w[8*i +: 8]);
               cs = cs ^ w[8*i +: 8];
            end
            exp_addr_q.push_back(BASE + 32'(4 * k));
            exp_data_q.push_back(w);
         end
         frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Streams up to nbytes of frame_q (all if negative); optional one-shot start pulse.
   task automatic send_frame(input int gap_pct, input int start_at, input int nbytes);
      int  idx, cyc, lim;
      bit  acc, fired;
      idx = 0; cyc = 0; fired = 0;
      lim = (nbytes < 0) ? frame_q.size() : nbytes;
      while (idx < lim && cyc < 4000) begin
         @(negedge clk);
         byte_valid_i = ($urandom_range(99) >= 32'(gap_pct));
         byte_i       = frame_q[idx];
         start_i      = 1'b0;
         if (!fired && idx == start_at) begin
            start_i = 1'b1;
            fired   = 1;
         end
         #1 acc = byte_valid_i && byte_ready_o;
         @(posedge clk);
         if (acc) idx++;
         cyc++;
      end
      @(negedge clk);
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      if (idx < lim) check("send_timeout", idx, lim);
   endtask

   task automatic run_load(input logic [31:0] n, input bit bad, input int gap, input int start_at);
      int  w0, cyc;
      bit  ovf, ok;
      ovf = (n > 32'(DEPTH));
      build_frame(n, bad);
      w0 = n_writes;
      start_pulse();
      check("ready_after_start", byte_ready_o, 1);
      check("hold_in_load", cpu_hold_o, 1);
      check("cnt_cleared", word_cnt_o, 0);
      send_frame(gap, start_at, -1);
      cyc = 0;
      while (!(load_done_o || load_err_o) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      check("done", load_done_o, (!ovf && !bad));
      check("err", load_err_o, (ovf || bad));
      check("hold", cpu_hold_o, (ovf || bad));
      check("ready_end", byte_ready_o, 0);
      check("word_cnt", word_cnt_o, ovf ? 0 : n);
      check("write_count", n_writes - w0, ovf ? 0 : n);
      check("missing_writes", exp_addr_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, byte_ready_o, 0);
      check({tag, "_wr_en"}, wr_en_o, 0);
      check({tag, "_wr_addr"}, wr_addr_o, BASE);
      check({tag, "_wr_data"}, wr_data_o, 0);
      check({tag, "_hold"}, cpu_hold_o, 1);
      check({tag, "_done"}, load_done_o, 0);
      check({tag, "_err"}, load_err_o, 0);
      check({tag, "_cnt"}, word_cnt_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, sa;
      bit bad;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("idle");

      // directed two-word image, good then bad checksum
      pay_q = '{32'h0000_0013, 32'h0000_0537};
      run_load(32'd2, 1'b0, 0, -1);
      run_load(32'd2, 1'b1, 0, -1);

      // header overflow, empty image, full-depth image
      pay_q.delete();
      run_load(32'(DEPTH + 1), 1'b0, 0, -1);
      run_load(32'd0, 1'b0, 0, -1);
      pay_q.delete();
      for (int k = 0; k < DEPTH; k++) pay_q.push_back($urandom());
      run_load(32'(DEPTH), 1'b0, 0, -1);

      // random images with valid gaps and a stray start pulse during payload
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(DEPTH, 1);
         pay_q.delete();
         for (int k = 0; k < n; k++) pay_q.push_back($urandom());
         bad = ($urandom_range(3) == 0);
         sa  = 4 + $urandom_range(4 * n - 1);
         run_load(32'(n), bad, 35, sa);
      end

      // reset after 5 payload bytes, then a clean reload
      pay_q = '{32'h0000_0013, 32'h0000_0537};
      build_frame(32'd2, 1'b0);
      begin
         int w0;
         w0 = n_writes;
         start_pulse();
         send_frame(0, -1, 9);
         rst = 1'b1;
         #1;
         check_reset_outputs("midrst");
         check("midrst_writes", n_writes - w0, 1);
         exp_addr_q.delete();
         exp_data_q.delete();
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
      end
      run_load(32'd2, 1'b0, 20, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
